// File: rtl/tile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tile_pkg
//  Description : Shared types and width helpers for the tile egress path.
//  Revision    : 1.0 - initial release
// ============================================================================
package tile_pkg;

    localparam int FLIT_W_DEF = 32;

    typedef logic [FLIT_W_DEF-1:0] flit_t;

    typedef enum logic {
        ARB_RR   = 1'b0,
        ARB_PRIO = 1'b1
    } arb_mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } fsm_state_e;

    // Width needed to hold a credit count in the range 0..depth inclusive.
    function automatic int cred_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of an index over n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : tile_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational rotating-priority arbiter. The search starts at
//                ptr and wraps; ptr tied to 0 gives lowest-index priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;
    int   idx;

    // First requester found walking upward from ptr wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/tile_egress_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tile_egress_arbiter
//  Description : Credit-aware wormhole arbiter merging NUM_SRCS flit sources
//                into one switch input port with NUM_VCS virtual channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_egress_arbiter
    import tile_pkg::*;
#(
    parameter int        NUM_SRCS    = 4,
    parameter int        NUM_VCS     = 2,
    parameter int        BUFFER_SIZE = 8,
    parameter int        FLIT_W      = 32,
    parameter arb_mode_e ARB_MODE    = ARB_RR,
    localparam int       VC_W        = idx_width(NUM_VCS),
    localparam int       CRED_W      = cred_width(BUFFER_SIZE)
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [NUM_SRCS-1:0]          src_valid,
    output logic [NUM_SRCS-1:0]          src_ready,
    input  logic [NUM_SRCS*FLIT_W-1:0]   src_flit,
    input  logic [NUM_SRCS*VC_W-1:0]     src_vc,
    input  logic [NUM_SRCS-1:0]          src_last,
    output logic                         out_valid,
    output logic [FLIT_W-1:0]            out_flit,
    output logic [VC_W-1:0]              out_vc,
    input  logic [NUM_VCS-1:0]           credit_return,
    output logic [NUM_VCS*CRED_W-1:0]    credits,
    output logic                         credit_err
);

    localparam int SRC_W = idx_width(NUM_SRCS);

    logic [NUM_VCS-1:0]  cred_ok;
    logic [NUM_VCS-1:0]  cred_ovf;
    logic [NUM_SRCS-1:0] req;
    logic [NUM_SRCS-1:0] arb_grant;
    logic [SRC_W-1:0]    arb_ptr;
    logic                xfer;
    logic [SRC_W-1:0]    win_idx;
    logic [VC_W-1:0]     win_vc;
    logic [FLIT_W-1:0]   win_flit;
    logic                win_last;
    logic [VC_W-1:0]     send_vc;
    logic [VC_W-1:0]     vc_i;

    fsm_state_e          state_q, state_d;
    logic [SRC_W-1:0]    owner_q, owner_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [VC_W-1:0]     lock_vc_q, lock_vc_d;
    logic                out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]   out_flit_q, out_flit_d;
    logic [VC_W-1:0]     out_vc_q, out_vc_d;
    logic                err_q, err_d;

    // Qualify requests: credit on the target VC, and only the owner while locked.
    always_comb begin
        req  = '0;
        vc_i = '0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            vc_i = src_vc[i*VC_W +: VC_W];
            if (state_q == LOCKED) begin
                req[i] = src_valid[i] && (SRC_W'(i) == owner_q)
                         && (int'(lock_vc_q) < NUM_VCS) && cred_ok[lock_vc_q];
            end else begin
                req[i] = src_valid[i] && (int'(vc_i) < NUM_VCS) && cred_ok[vc_i];
            end
        end
    end

    assign arb_ptr = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_SRCS),
        .PTR_W   (SRC_W)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (arb_ptr),
        .grant (arb_grant)
    );

    // No grant may escape while reset is held, even though the arbiter is combinational.
    assign src_ready = arb_grant & {NUM_SRCS{n_rst}};
    assign xfer      = |src_ready;

    // Steer the winning source's flit, VC and tail flag.
    always_comb begin
        win_idx  = '0;
        win_vc   = '0;
        win_flit = '0;
        win_last = 1'b0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            if (arb_grant[i]) begin
                win_idx  = SRC_W'(i);
                win_vc   = src_vc[i*VC_W +: VC_W];
                win_flit = src_flit[i*FLIT_W +: FLIT_W];
                win_last = src_last[i];
            end
        end
    end

    // Mid-packet the VC captured at the head flit is authoritative.
    assign send_vc = (state_q == LOCKED) ? lock_vc_q : win_vc;

    // Next-state for packet lock, round-robin pointer, output stage and error flag.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lock_vc_d   = lock_vc_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = xfer;
        out_flit_d  = out_flit_q;
        out_vc_d    = out_vc_q;
        err_d       = err_q | (|cred_ovf);

        if (xfer) begin
            out_flit_d = win_flit;
            out_vc_d   = send_vc;
        end

        case (state_q)
            IDLE: begin
                if (xfer && !win_last) begin
                    state_d   = LOCKED;
                    owner_d   = win_idx;
                    lock_vc_d = win_vc;
                end
            end
            LOCKED: begin
                if (xfer && win_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (xfer && win_last) begin
            rr_ptr_d = (win_idx == SRC_W'(NUM_SRCS - 1)) ? '0 : win_idx + SRC_W'(1);
        end
    end

    // Control FSM and registered output stage.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            lock_vc_q   <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_vc_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lock_vc_q   <= lock_vc_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_vc_q    <= out_vc_d;
            err_q       <= err_d;
        end
    end

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_credit
        logic [CRED_W-1:0] cnt_q, cnt_d;
        logic              send;
        logic              ovf;

        // Count = count - send + return; a return with no room saturates and flags.
        always_comb begin
            send  = xfer && (send_vc == VC_W'(v));
            cnt_d = cnt_q;
            ovf   = 1'b0;
            if (send && !credit_return[v]) begin
                cnt_d = cnt_q - CRED_W'(1);
            end else if (!send && credit_return[v]) begin
                if (cnt_q == CRED_W'(BUFFER_SIZE)) begin
                    ovf = 1'b1;
                end else begin
                    cnt_d = cnt_q + CRED_W'(1);
                end
            end
        end

        // Per-VC credit register, reloaded to a full downstream buffer on reset.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                cnt_q <= CRED_W'(BUFFER_SIZE);
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign credits[v*CRED_W +: CRED_W] = cnt_q;
        assign cred_ok[v]                  = |cnt_q;
        assign cred_ovf[v]                 = ovf;
    end

    assign out_valid  = out_valid_q;
    assign out_flit   = out_flit_q;
    assign out_vc     = out_vc_q;
    assign credit_err = err_q;

endmodule : tile_egress_arbiter
`default_nettype wire

// File: tb/tb_tile_egress_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_egress_arbiter
//  Description : Directed self-checking bench for tile_egress_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_egress_arbiter;
    import tile_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [3:0]  src_valid, src_ready, src_last, src_vc;
    logic [127:0] src_flit;
    logic        out_valid;
    logic [31:0] out_flit;
    logic        out_vc;
    logic [1:0]  credit_return;
    logic [7:0]  credits;
    logic        credit_err;

    logic [3:0]  p_src_valid, p_src_ready, p_src_last, p_src_vc;
    logic [127:0] p_src_flit;
    logic        p_out_valid;
    logic [31:0] p_out_flit;
    logic        p_out_vc;
    logic [7:0]  p_credits;
    logic        p_credit_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tile_egress_arbiter #(
        .NUM_SRCS(4), .NUM_VCS(2), .BUFFER_SIZE(8), .FLIT_W(32), .ARB_MODE(ARB_RR)
    ) u_dut (
        .clk(clk), .n_rst(n_rst),
        .src_valid(src_valid), .src_ready(src_ready), .src_flit(src_flit),
        .src_vc(src_vc), .src_last(src_last),
        .out_valid(out_valid), .out_flit(out_flit), .out_vc(out_vc),
        .credit_return(credit_return), .credits(credits), .credit_err(credit_err)
    );

    tile_egress_arbiter #(
        .NUM_SRCS(4), .NUM_VCS(2), .BUFFER_SIZE(8), .FLIT_W(32), .ARB_MODE(ARB_PRIO)
    ) u_prio (
        .clk(clk), .n_rst(n_rst),
        .src_valid(p_src_valid), .src_ready(p_src_ready), .src_flit(p_src_flit),
        .src_vc(p_src_vc), .src_last(p_src_last),
        .out_valid(p_out_valid), .out_flit(p_out_flit), .out_vc(p_out_vc),
        .credit_return(2'b00), .credits(p_credits), .credit_err(p_credit_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_src(input int i, input logic v, input flit_t f, input logic vc, input logic last);
        src_valid[i]          = v;
        src_flit[i*32 +: 32]  = f;
        src_vc[i]             = vc;
        src_last[i]           = last;
    endtask

    task automatic clr_src();
        src_valid = '0;
        src_last  = '0;
        src_vc    = '0;
        src_flit  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_rst         = 1'b0;
        credit_return = 2'b00;
        clr_src();
        p_src_valid = '0;
        p_src_last  = '0;
        p_src_vc    = '0;
        p_src_flit  = '0;

        // Reset state
        set_src(0, 1'b1, 32'h1111, 1'b0, 1'b1);
        settle();
        check("rst_ready", 64'(src_ready), 64'(4'b0000));
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_out_flit", 64'(out_flit), 64'(32'h0));
        check("rst_out_vc", 64'(out_vc), 64'(1'b0));
        check("rst_credits", 64'(credits), 64'(8'h88));
        check("rst_credit_err", 64'(credit_err), 64'(1'b0));
        clr_src();
        n_rst = 1'b1;
        tick();

        // Round-robin, two 2-flit packets from src0 and src2, no interleave
        set_src(0, 1'b1, 32'hB000, 1'b0, 1'b0);
        set_src(2, 1'b1, 32'hC000, 1'b0, 1'b0);
        settle();
        check("rr_first", 64'(src_ready), 64'(4'b0001));
        tick();
        check("rr_b0_valid", 64'(out_valid), 64'(1'b1));
        check("rr_b0_flit", 64'(out_flit), 64'(32'hB000));
        set_src(0, 1'b1, 32'hB001, 1'b0, 1'b1);
        settle();
        check("rr_lock0", 64'(src_ready), 64'(4'b0001));
        tick();
        check("rr_b1_flit", 64'(out_flit), 64'(32'hB001));
        set_src(0, 1'b0, 32'h0, 1'b0, 1'b0);
        settle();
        check("rr_src2", 64'(src_ready), 64'(4'b0100));
        tick();
        check("rr_c0_flit", 64'(out_flit), 64'(32'hC000));
        set_src(0, 1'b1, 32'hD000, 1'b0, 1'b0);
        set_src(2, 1'b1, 32'hC001, 1'b0, 1'b1);
        settle();
        check("rr_lock2", 64'(src_ready), 64'(4'b0100));
        tick();
        check("rr_c1_flit", 64'(out_flit), 64'(32'hC001));
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, flit_t'(32'hE000 + i), 1'b0, 1'b1);
        settle();
        check("rr_ptr3", 64'(src_ready), 64'(4'b1000));
        tick();
        check("rr_e3_flit", 64'(out_flit), 64'(32'hE003));
        settle();
        check("rr_wrap", 64'(src_ready), 64'(4'b0001));
        clr_src();
        settle();
        check("rr_credits", 64'(credits), 64'(8'h83));

        // Send and return on a VC at 3 leaves it at 3
        set_src(0, 1'b1, 32'hF000, 1'b0, 1'b1);
        credit_return = 2'b01;
        settle();
        check("sr3_ready", 64'(src_ready), 64'(4'b0001));
        tick();
        credit_return = 2'b00;
        clr_src();
        check("sr3_credits", 64'(credits), 64'(8'h83));
        check("sr3_flit", 64'(out_flit), 64'(32'hF000));
        credit_return = 2'b01;
        repeat (5) tick();
        credit_return = 2'b00;
        settle();
        check("restore1", 64'(credits), 64'(8'h88));

        // Single source, 3-flit packet on VC0
        check("p3_idle", 64'(out_valid), 64'(1'b0));
        set_src(0, 1'b1, 32'hA000, 1'b0, 1'b0);
        settle();
        check("p3_ready", 64'(src_ready), 64'(4'b0001));
        tick();
        check("p3_v0", 64'(out_valid), 64'(1'b1));
        check("p3_f0", 64'(out_flit), 64'(32'hA000));
        check("p3_cred0", 64'(credits), 64'(8'h87));
        set_src(0, 1'b1, 32'hA001, 1'b0, 1'b0);
        tick();
        check("p3_v1", 64'(out_valid), 64'(1'b1));
        check("p3_f1", 64'(out_flit), 64'(32'hA001));
        set_src(0, 1'b1, 32'hA002, 1'b0, 1'b1);
        tick();
        check("p3_v2", 64'(out_valid), 64'(1'b1));
        check("p3_f2", 64'(out_flit), 64'(32'hA002));
        check("p3_cred", 64'(credits), 64'(8'h85));
        clr_src();
        tick();
        check("p3_end", 64'(out_valid), 64'(1'b0));
        credit_return = 2'b01;
        repeat (3) tick();
        credit_return = 2'b00;
        settle();
        check("restore2", 64'(credits), 64'(8'h88));

        // Drain VC1; VC0 keeps flowing; one return reopens VC1 a cycle later
        set_src(3, 1'b1, 32'h6000, 1'b1, 1'b1);
        repeat (8) tick();
        clr_src();
        settle();
        check("drain_cred", 64'(credits), 64'(8'h08));
        check("drain_vc", 64'(out_vc), 64'(1'b1));
        set_src(1, 1'b1, 32'h7001, 1'b1, 1'b1);
        set_src(2, 1'b1, 32'h7002, 1'b0, 1'b1);
        settle();
        check("vc_block", 64'(src_ready), 64'(4'b0100));
        tick();
        check("vc0_pass_vc", 64'(out_vc), 64'(1'b0));
        check("vc0_pass_flit", 64'(out_flit), 64'(32'h7002));
        set_src(2, 1'b0, 32'h0, 1'b0, 1'b0);
        credit_return = 2'b10;
        settle();
        check("zero_ret_ready", 64'(src_ready), 64'(4'b0000));
        tick();
        credit_return = 2'b00;
        settle();
        check("zero_ret_cred", 64'(credits), 64'(8'h17));
        check("zero_ret_idle", 64'(out_valid), 64'(1'b0));
        check("vc1_reopen", 64'(src_ready), 64'(4'b0010));
        tick();
        check("vc1_out_vc", 64'(out_vc), 64'(1'b1));
        check("vc1_out_flit", 64'(out_flit), 64'(32'h7001));
        check("vc1_cred", 64'(credits), 64'(8'h07));
        clr_src();
        credit_return = 2'b11;
        tick();
        credit_return = 2'b10;
        repeat (7) tick();
        credit_return = 2'b00;
        settle();
        check("restore3", 64'(credits), 64'(8'h88));

        // Overflow on a full VC saturates and sets the sticky error
        credit_return = 2'b01;
        tick();
        credit_return = 2'b00;
        settle();
        check("ovf_cred", 64'(credits), 64'(8'h88));
        check("ovf_err", 64'(credit_err), 64'(1'b1));
        repeat (3) tick();
        check("ovf_sticky", 64'(credit_err), 64'(1'b1));

        // Asynchronous reset while src1 holds the lock
        set_src(1, 1'b1, 32'h9000, 1'b0, 1'b0);
        settle();
        check("lock1_ready", 64'(src_ready), 64'(4'b0010));
        tick();
        check("lock1_cred", 64'(credits), 64'(8'h87));
        n_rst = 1'b0;
        settle();
        check("arst_valid", 64'(out_valid), 64'(1'b0));
        check("arst_flit", 64'(out_flit), 64'(32'h0));
        check("arst_cred", 64'(credits), 64'(8'h88));
        check("arst_err", 64'(credit_err), 64'(1'b0));
        check("arst_ready", 64'(src_ready), 64'(4'b0000));
        tick();
        n_rst = 1'b1;
        set_src(0, 1'b1, 32'hAA00, 1'b0, 1'b1);
        set_src(1, 1'b1, 32'h9001, 1'b0, 1'b0);
        settle();
        check("post_rst_src0", 64'(src_ready), 64'(4'b0001));
        tick();
        check("post_rst_flit", 64'(out_flit), 64'(32'hAA00));
        clr_src();

        // Priority mode: lowest index always wins
        p_src_valid = 4'b1111;
        p_src_last  = 4'b1111;
        settle();
        check("prio_first", 64'(p_src_ready), 64'(4'b0001));
        tick();
        settle();
        check("prio_again", 64'(p_src_ready), 64'(4'b0001));
        p_src_valid = 4'b1110;
        settle();
        check("prio_next", 64'(p_src_ready), 64'(4'b0010));
        p_src_valid = 4'b0000;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_tile_egress_arbiter
`default_nettype wire
